// File: rtl/coeff_ctrl_pkg.sv
// Shared types and widths for the coefficient reload controller.
// range_ok() decides whether a reload request fits inside the coefficient RAM.
package coeff_ctrl_pkg;

  localparam int DATA_W  = 4;
  localparam int COEFF_W = 8;
  localparam int ADDR_W  = 7;
  localparam int LEN_W   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  // Sum is formed one bit wider than the length so base+len cannot wrap.
  function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                    input logic [LEN_W-1:0]  len,
                                    input int                num_taps);
    logic [LEN_W:0] end_addr;
    end_addr = {2'b00, base} + {1'b0, len};
    return (len != '0) && (int'(len) <= num_taps) && (int'(end_addr) <= num_taps);
  endfunction

endpackage

// File: rtl/coeff_load_ctrl.sv
// Gates the sample path, drains the filter, then streams cfg_len coefficients into RAM.
// Samples forwarded with 1-cycle latency in IDLE; cfg_ready only in LOAD, stalls unbounded.
module coeff_load_ctrl
  import coeff_ctrl_pkg::*;
#(
  parameter int NUM_TAPS     = 128,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_valid,
  input  logic [COEFF_W-1:0] cfg_data,
  output logic               cfg_ready,
  output logic               cfg_busy,
  output logic               cfg_done,
  output logic               cfg_err,
  input  logic [DATA_W-1:0]  s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_W-1:0]  f_data_in,
  output logic               f_data_valid,
  output logic               f_coeff_we,
  output logic [ADDR_W-1:0]  f_coeff_addr,
  output logic [COEFF_W-1:0] f_coeff_data
);

  localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  state_t              state;
  logic [DCNT_W-1:0]   drain_cnt;
  logic [ADDR_W-1:0]   base_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx;

  // Handshake strobes decode straight from the state register.
  assign s_ready   = (state == IDLE);
  assign cfg_ready = (state == LOAD);
  assign cfg_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      base_q       <= '0;
      len_q        <= '0;
      idx          <= '0;
      f_data_in    <= '0;
      f_data_valid <= 1'b0;
      f_coeff_we   <= 1'b0;
      f_coeff_addr <= '0;
      f_coeff_data <= '0;
      cfg_done     <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      // A sample taken in the same cycle as cfg_start still reaches the filter.
      f_data_valid <= s_valid && s_ready;
      if (s_ready) begin
        f_data_in <= s_data;
      end
      f_coeff_we <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (range_ok(cfg_base, cfg_len, NUM_TAPS)) begin
              base_q    <= cfg_base;
              len_q     <= cfg_len;
              idx       <= '0;
              drain_cnt <= '0;
              state     <= (DRAIN_CYCLES == 0) ? LOAD : DRAIN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end

        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= LOAD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        LOAD: begin
          if (cfg_valid) begin
            f_coeff_we   <= 1'b1;
            f_coeff_addr <= ADDR_W'({1'b0, base_q} + idx);
            f_coeff_data <= cfg_data;
            idx          <= idx + 1'b1;
            if (idx == len_q - 1'b1) begin
              state <= SETTLE;
            end
          end
        end

        SETTLE: begin
          cfg_done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_load_ctrl.sv
// Randomized bench for coeff_load_ctrl against a transaction-level model and a shadow coefficient RAM.
module tb_coeff_load_ctrl;

  localparam int NUM_TAPS = 128;
  localparam int DRAIN    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic [6:0] cfg_base;
  logic [7:0] cfg_len;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready, cfg_busy, cfg_done, cfg_err;
  logic [3:0] s_data;
  logic       s_valid, s_ready;
  logic [3:0] f_data_in;
  logic       f_data_valid, f_coeff_we;
  logic [6:0] f_coeff_addr;
  logic [7:0] f_coeff_data;

  always #5 clk = ~clk;

  coeff_load_ctrl #(.NUM_TAPS(NUM_TAPS), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst(rst),
    .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_valid(cfg_valid), .cfg_data(cfg_data), .cfg_ready(cfg_ready),
    .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .f_data_in(f_data_in), .f_data_valid(f_data_valid),
    .f_coeff_we(f_coeff_we), .f_coeff_addr(f_coeff_addr), .f_coeff_data(f_coeff_data)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_mem [NUM_TAPS];
  logic [7:0] dut_mem [NUM_TAPS];
  int exp_writes = 0;
  int dut_writes = 0;
  logic [7:0] load_words [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cfg_ok(input int base, input int len);
    return (len >= 1) && (len <= NUM_TAPS) && (base + len <= NUM_TAPS);
  endfunction

  // Shadow RAM: whatever the filter would actually have stored.
  always @(negedge clk) begin
    if (f_coeff_we) begin
      dut_mem[f_coeff_addr] = f_coeff_data;
      dut_writes++;
    end
  end

  task automatic passthru(input int n);
    bit       v;
    bit [3:0] d;
    for (int i = 0; i < n; i++) begin
      v = 1'($urandom_range(0, 1));
      d = 4'($urandom_range(0, 15));
      s_valid = v;
      s_data  = d;
      tick();
      chk("pt_vld", 32'(f_data_valid), 32'(v));
      if (v) chk("pt_dat", 32'(f_data_in), 32'(d));
    end
    s_valid = 1'b0;
  endtask

  task automatic do_err(input int base, input int len);
    cfg_start = 1'b1;
    cfg_base  = 7'(base);
    cfg_len   = 8'(len);
    tick();
    cfg_start = 1'b0;
    chk("err_pulse", 32'(cfg_err), 1);
    chk("err_busy", 32'(cfg_busy), 0);
    chk("err_sready", 32'(s_ready), 1);
    tick();
    chk("err_once", 32'(cfg_err), 0);
    chk("err_busy2", 32'(cfg_busy), 0);
    chk("err_nowr", 32'(f_coeff_we), 0);
  endtask

  task automatic fill_words(input int len);
    load_words.delete();
    for (int i = 0; i < len; i++) load_words.push_back(8'($urandom_range(0, 255)));
  endtask

  // Model: DRAIN gated cycles, then word i lands at base+i exactly one cycle after its handshake.
  task automatic do_load(input int base, input int len, input int stall_pct,
                         input int stall_at, input bit collide, input bit abort);
    int n;
    int accepted;
    int cyc;
    int stall_left;
    bit v;
    stall_left = 3;
    cfg_start = 1'b1;
    cfg_base  = 7'(base);
    cfg_len   = 8'(len);
    if (collide) begin
      s_valid = 1'b1;
      s_data  = 4'd7;
    end
    tick();
    cfg_start = 1'b0;
    s_valid   = 1'b0;
    chk("busy_on", 32'(cfg_busy), 1);
    if (collide) begin
      chk("coll_vld", 32'(f_data_valid), 1);
      chk("coll_dat", 32'(f_data_in), 7);
    end

    n = 0;
    while (!cfg_ready && n < 100) begin
      n++;
      chk("drain_sready", 32'(s_ready), 0);
      chk("drain_nowr", 32'(f_coeff_we), 0);
      chk("drain_noerr", 32'(cfg_err), 0);
      if (n > 1 || !collide) chk("drain_fvld", 32'(f_data_valid), 0);
      s_valid   = 1'($urandom_range(0, 1));
      s_data    = 4'($urandom_range(0, 15));
      cfg_start = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid   = 1'b0;
    cfg_start = 1'b0;
    chk("drain_len", 32'(n), 32'(DRAIN));

    accepted = 0;
    cyc      = 0;
    while (accepted < len && cyc < 2000) begin
      if (accepted == stall_at && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else begin
        v = ($urandom_range(0, 99) >= stall_pct);
      end
      chk("load_ready", 32'(cfg_ready), 1);
      cfg_valid = v;
      cfg_data  = v ? load_words[accepted] : 8'($urandom_range(0, 255));
      cfg_start = ($urandom_range(0, 3) == 0);
      cfg_len   = 8'd0;
      cfg_base  = 7'($urandom_range(0, 127));
      tick();
      cyc++;
      cfg_start = 1'b0;
      chk("load_we", 32'(f_coeff_we), 32'(v));
      chk("load_noerr", 32'(cfg_err), 0);
      chk("load_nodone", 32'(cfg_done), 0);
      if (v) begin
        chk("load_addr", 32'(f_coeff_addr), 32'(base + accepted));
        chk("load_data", 32'(f_coeff_data), 32'(load_words[accepted]));
        exp_mem[base + accepted] = load_words[accepted];
        exp_writes++;
        accepted++;
        if (abort) begin
          cfg_valid = 1'b0;
          rst = 1'b1;
          tick();
          chk("abort_we", 32'(f_coeff_we), 0);
          chk("abort_busy", 32'(cfg_busy), 0);
          chk("abort_done", 32'(cfg_done), 0);
          chk("abort_ready", 32'(cfg_ready), 0);
          rst = 1'b0;
          chk("abort_sready", 32'(s_ready), 1);
          tick();
          chk("abort_done2", 32'(cfg_done), 0);
          chk("abort_err2", 32'(cfg_err), 0);
          chk("abort_we2", 32'(f_coeff_we), 0);
          return;
        end
      end
    end
    chk("load_count", 32'(accepted), 32'(len));

    chk("settle_ready", 32'(cfg_ready), 0);
    chk("settle_busy", 32'(cfg_busy), 1);
    chk("settle_sready", 32'(s_ready), 0);
    cfg_valid = 1'($urandom_range(0, 1));
    cfg_data  = 8'($urandom_range(0, 255));
    tick();
    cfg_valid = 1'b0;
    chk("done_pulse", 32'(cfg_done), 1);
    chk("done_busy", 32'(cfg_busy), 0);
    chk("done_sready", 32'(s_ready), 1);
    chk("done_nowr", 32'(f_coeff_we), 0);
    tick();
    chk("done_once", 32'(cfg_done), 0);
  endtask

  initial begin
    int kind, b, l, tries;
    for (int i = 0; i < NUM_TAPS; i++) begin
      exp_mem[i] = 8'd0;
      dut_mem[i] = 8'd0;
    end
    rst = 1'b1;
    cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
    cfg_valid = 1'b0; cfg_data = '0;
    s_data = '0; s_valid = 1'b0;
    tick();
    tick();
    chk("rst_fvld", 32'(f_data_valid), 0);
    chk("rst_fdat", 32'(f_data_in), 0);
    chk("rst_we", 32'(f_coeff_we), 0);
    chk("rst_addr", 32'(f_coeff_addr), 0);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_done", 32'(cfg_done), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_ready", 32'(cfg_ready), 0);
    rst = 1'b0;
    chk("rst_sready", 32'(s_ready), 1);

    s_valid = 1'b1; s_data = 4'd3;
    tick();
    chk("pt3_vld", 32'(f_data_valid), 1);
    chk("pt3_dat", 32'(f_data_in), 3);
    s_data = 4'd5;
    tick();
    chk("pt5_vld", 32'(f_data_valid), 1);
    chk("pt5_dat", 32'(f_data_in), 5);
    s_valid = 1'b0;
    tick();
    chk("pt_idle", 32'(f_data_valid), 0);

    load_words.delete();
    load_words.push_back(8'd5);
    load_words.push_back(8'd10);
    do_load(0, 2, 0, -1, 1'b0, 1'b0);

    fill_words(2);
    do_load(126, 2, 0, 1, 1'b0, 1'b0);

    do_err(0, 0);
    do_err(120, 9);
    do_err(0, 129);
    do_err(127, 255);

    fill_words(4);
    do_load(40, 4, 0, -1, 1'b0, 1'b1);

    fill_words(3);
    do_load(10, 3, 20, -1, 1'b1, 1'b0);

    fill_words(8);
    do_load(120, 8, 25, -1, 1'b0, 1'b0);
    fill_words(1);
    do_load(127, 1, 0, -1, 1'b1, 1'b0);
    fill_words(128);
    do_load(0, 128, 10, 64, 1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        passthru($urandom_range(1, 8));
      end else if (kind == 1) begin
        b = 0; l = 0; tries = 0;
        do begin
          b = $urandom_range(0, 127);
          l = $urandom_range(0, 255);
          tries++;
        end while (cfg_ok(b, l) && tries < 20);
        if (cfg_ok(b, l)) l = 0;
        do_err(b, l);
      end else begin
        l = $urandom_range(1, 16);
        b = $urandom_range(0, NUM_TAPS - l);
        fill_words(l);
        do_load(b, l, 30, -1, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
      end
    end

    tick();
    for (int i = 0; i < NUM_TAPS; i++) chk("mem", 32'(dut_mem[i]), 32'(exp_mem[i]));
    chk("wr_count", 32'(dut_writes), 32'(exp_writes));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
